alu_op_sequencer: RTL and testbench

//  Control-step generator for register-register ALU instructions on the Datapath bus.

---
 rtl/alu_op_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Fetch/decode/execute control-step sequencer for register-register ALU instructions.
// Optional MUL/DIV support (ops 15/16, extra T6 step) is enabled by defining ALU_MULDIV_EN.
module alu_op_sequencer #(
  parameter int NUM_REGS    = 16,
  parameter int REG_IDX_W   = 4,
  parameter int OP_W        = 5,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                Clock,
  input  logic                Clear,
  input  logic                start,
  input  logic [31:0]         ir,
  output logic                busy,
  output logic                done,
  output logic                illegal,
  output logic                PCout,
  output logic                MARin,
  output logic                IncPC,
  output logic                Zin,
  output logic                Zlowout,
  output logic                ZHighout,
  output logic                PCin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                LOin,
  output logic                HIin,
  output logic [NUM_REGS-1:0] reg_out_sel,
  output logic [NUM_REGS-1:0] reg_in_sel,
  output logic [OP_W-1:0]     alu_op
);

  localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5,
`ifdef ALU_MULDIV_EN
    S_T6,
`endif
    S_DONE
  } state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      wait_cnt_reg;
  logic [OP_W-1:0]       op_reg;
  logic [NUM_REGS-1:0]   ra_hot_reg, rc_hot_reg;
  logic                  illegal_reg;
`ifdef ALU_MULDIV_EN
  logic                  md_reg;
`endif

  // Instruction fields, packed downward from bit 26 below the opcode.
  logic [OP_W-1:0]       dec_op;
  logic [REG_IDX_W-1:0]  dec_ra, dec_rb, dec_rc;
  logic [NUM_REGS-1:0]   ra_hot, rb_hot, rc_hot;
  logic                  dec_alu, dec_md, dec_legal;
  logic                  ir_unused;

  assign dec_op    = ir[31 -: OP_W];
  assign dec_ra    = ir[26 -: REG_IDX_W];
  assign dec_rb    = ir[26-REG_IDX_W -: REG_IDX_W];
  assign dec_rc    = ir[26-2*REG_IDX_W -: REG_IDX_W];
  assign ir_unused = ^ir[26-3*REG_IDX_W:0];

  // An index outside the register file leaves its one-hot vector all zero.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_hot
    assign ra_hot[gi] = (dec_ra == REG_IDX_W'(gi));
    assign rb_hot[gi] = (dec_rb == REG_IDX_W'(gi));
    assign rc_hot[gi] = (dec_rc == REG_IDX_W'(gi));
  end

  assign dec_alu = (dec_op <= OP_W'(8));
`ifdef ALU_MULDIV_EN
  assign dec_md    = (dec_op == OP_W'(15)) || (dec_op == OP_W'(16));
  assign dec_legal = (dec_alu || dec_md) && (|rb_hot) && (|rc_hot) && (dec_md || (|ra_hot));
`else
  assign dec_md    = 1'b0;
  assign dec_legal = dec_alu && !dec_md && (|rb_hot) && (|rc_hot) && (|ra_hot);
`endif

  always_ff @(posedge Clock) begin
    if (Clear) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      wait_cnt_reg <= '0;
      op_reg       <= '0;
      ra_hot_reg   <= '0;
      rc_hot_reg   <= '0;
      illegal_reg  <= 1'b0;
`ifdef ALU_MULDIV_EN
      md_reg       <= 1'b0;
`endif
    end else begin
      if (state_reg == S_T0)
        wait_cnt_reg <= CNT_W'(WAIT_CYCLES);
      else if (state_reg == S_T1)
        wait_cnt_reg <= wait_cnt_reg - CNT_W'(1);
      // IR may change after T3, so execute steps use these captured fields.
      if (state_reg == S_T3) begin
        op_reg      <= dec_op;
        ra_hot_reg  <= ra_hot;
        rc_hot_reg  <= rc_hot;
        illegal_reg <= !dec_legal;
`ifdef ALU_MULDIV_EN
        md_reg      <= dec_md;
`endif
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (start) state_next = S_T0;
      S_T0:   state_next = S_T1;
      S_T1:   if (wait_cnt_reg == CNT_W'(1)) state_next = S_T2;
      S_T2:   state_next = S_T3;
      S_T3:   state_next = dec_legal ? S_T4 : S_DONE;
      S_T4:   state_next = S_T5;
`ifdef ALU_MULDIV_EN
      S_T5:   state_next = md_reg ? S_T6 : S_DONE;
      S_T6:   state_next = S_DONE;
`else
      S_T5:   state_next = S_DONE;
`endif
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    PCout       = 1'b0;
    MARin       = 1'b0;
    IncPC       = 1'b0;
    Zin         = 1'b0;
    Zlowout     = 1'b0;
    ZHighout    = 1'b0;
    PCin        = 1'b0;
    Read        = 1'b0;
    MDRin       = 1'b0;
    MDRout      = 1'b0;
    IRin        = 1'b0;
    Yin         = 1'b0;
    LOin        = 1'b0;
    HIin        = 1'b0;
    reg_out_sel = '0;
    reg_in_sel  = '0;
    alu_op      = '0;
    case (state_reg)
      S_T0: begin
        busy  = 1'b1;
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        busy    = 1'b1;
        Zlowout = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        PCin    = (wait_cnt_reg == CNT_W'(WAIT_CYCLES));
      end
      S_T2: begin
        busy   = 1'b1;
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        busy = 1'b1;
        if (dec_legal) begin
          reg_out_sel = rb_hot;
          Yin         = 1'b1;
        end
      end
      S_T4: begin
        busy        = 1'b1;
        reg_out_sel = rc_hot_reg;
        alu_op      = op_reg;
        Zin         = 1'b1;
      end
      S_T5: begin
        busy    = 1'b1;
        Zlowout = 1'b1;
`ifdef ALU_MULDIV_EN
        if (md_reg) LOin       = 1'b1;
        else        reg_in_sel = ra_hot_reg;
`else
        reg_in_sel = ra_hot_reg;
`endif
      end
`ifdef ALU_MULDIV_EN
      S_T6: begin
        busy     = 1'b1;
        ZHighout = 1'b1;
        HIin     = 1'b1;
      end
`endif
      S_DONE: begin
        done    = 1'b1;
        illegal = illegal_reg;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (one and three memory wait cycles) compared cycle
// by cycle against a step-list model of the instruction flow; honours ALU_MULDIV_EN.
module tb_alu_op_sequencer;

  typedef struct packed {
    logic busy, done, illegal, PCout, MARin, IncPC, Zin, Zlowout, ZHighout;
    logic PCin, Read, MDRin, MDRout, IRin, Yin, LOin, HIin;
    logic [15:0] out_sel;
    logic [15:0] in_sel;
    logic [4:0]  alu_op;
  } out_t;

`ifdef ALU_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic        Clock;
  logic        Clear;
  logic [31:0] ir;
  logic        start [2];
  logic        busy [2], done [2], illegal [2], PCout [2], MARin [2], IncPC [2], Zin [2];
  logic        Zlowout [2], ZHighout [2], PCin [2], Read [2], MDRin [2], MDRout [2];
  logic        IRin [2], Yin [2], LOin [2], HIin [2];
  logic [15:0] reg_out_sel [2], reg_in_sel [2];
  logic [4:0]  alu_op [2];
  out_t        obs [2];

  int checks = 0;
  int fails  = 0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    alu_op_sequencer #(.NUM_REGS(16), .REG_IDX_W(4), .OP_W(5), .WAIT_CYCLES(gi == 0 ? 1 : 3)) dut (
      .Clock(Clock), .Clear(Clear), .start(start[gi]), .ir(ir),
      .busy(busy[gi]), .done(done[gi]), .illegal(illegal[gi]),
      .PCout(PCout[gi]), .MARin(MARin[gi]), .IncPC(IncPC[gi]), .Zin(Zin[gi]),
      .Zlowout(Zlowout[gi]), .ZHighout(ZHighout[gi]), .PCin(PCin[gi]), .Read(Read[gi]),
      .MDRin(MDRin[gi]), .MDRout(MDRout[gi]), .IRin(IRin[gi]), .Yin(Yin[gi]),
      .LOin(LOin[gi]), .HIin(HIin[gi]),
      .reg_out_sel(reg_out_sel[gi]), .reg_in_sel(reg_in_sel[gi]), .alu_op(alu_op[gi])
    );
    assign obs[gi] = {busy[gi], done[gi], illegal[gi], PCout[gi], MARin[gi], IncPC[gi], Zin[gi],
                      Zlowout[gi], ZHighout[gi], PCin[gi], Read[gi], MDRin[gi], MDRout[gi],
                      IRin[gi], Yin[gi], LOin[gi], HIin[gi],
                      reg_out_sel[gi], reg_in_sel[gi], alu_op[gi]};
  end

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic bit is_md(input int op);
    return MD_EN && (op == 15 || op == 16);
  endfunction

  function automatic bit is_legal(input int op);
    return (op <= 8) || is_md(op);
  endfunction

  // Cycles from T0 through DONE inclusive.
  function automatic int trace_len(input int w, input int op);
    if (!is_legal(op)) return w + 4;
    return is_md(op) ? w + 7 : w + 6;
  endfunction

  // Expected outputs idx cycles after start was accepted (idx 0 = T0).
  function automatic out_t expect_at(input int w, input int op, input int ra, input int rb,
                                     input int rc, input int idx);
    out_t e;
    int   len;
    e   = '0;
    len = trace_len(w, op);
    if (idx < 0 || idx >= len) return e;
    if (idx == len - 1) begin
      e.done    = 1'b1;
      e.illegal = !is_legal(op);
      return e;
    end
    e.busy = 1'b1;
    if (idx == 0) begin
      e.PCout = 1'b1; e.MARin = 1'b1; e.IncPC = 1'b1; e.Zin = 1'b1;
    end else if (idx <= w) begin
      e.Zlowout = 1'b1; e.Read = 1'b1; e.MDRin = 1'b1; e.PCin = (idx == 1);
    end else if (idx == w + 1) begin
      e.MDRout = 1'b1; e.IRin = 1'b1;
    end else if (idx == w + 2) begin
      if (is_legal(op)) begin
        e.out_sel[rb] = 1'b1; e.Yin = 1'b1;
      end
    end else if (idx == w + 3) begin
      e.out_sel[rc] = 1'b1; e.alu_op = 5'(op); e.Zin = 1'b1;
    end else if (idx == w + 4) begin
      e.Zlowout = 1'b1;
      if (is_md(op)) e.LOin = 1'b1;
      else           e.in_sel[ra] = 1'b1;
    end else begin
      e.ZHighout = 1'b1; e.HIin = 1'b1;
    end
    return e;
  endfunction

  // n back-to-back launches with start held high: one IDLE cycle separates them.
  function automatic out_t expect_seq(input int w, input int op, input int ra, input int rb,
                                      input int rc, input int n, input int g);
    int period;
    period = trace_len(w, op) + 1;
    if (g / period >= n) return '0;
    return expect_at(w, op, ra, rb, rc, g % period);
  endfunction

  task automatic check(input string tag, input out_t o, input out_t e);
    checks++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic run(input int op, input int ra, input int rb, input int rc,
                     input int n0, input int n1, input int abort_at);
    int len0, len1, total;
    len0  = trace_len(1, op);
    len1  = trace_len(3, op);
    total = ((n0 * (len0 + 1)) > (n1 * (len1 + 1)) ? n0 * (len0 + 1) : n1 * (len1 + 1)) + 1;
    ir       = {5'(op), 4'(ra), 4'(rb), 4'(rc), 15'($urandom)};
    start[0] = (n0 > 0);
    start[1] = (n1 > 0);
    $display("txn op=%0d ra=%0d rb=%0d rc=%0d launches=%0d/%0d abort_at=%0d",
             op, ra, rb, rc, n0, n1, abort_at);
    @(posedge Clock); #1;
    for (int g = 0; g < total; g++) begin
      check($sformatf("w1_op%0d_c%0d", op, g), obs[0], expect_seq(1, op, ra, rb, rc, n0, g));
      check($sformatf("w3_op%0d_c%0d", op, g), obs[1], expect_seq(3, op, ra, rb, rc, n1, g));
      if (n0 > 0 && g == (n0 - 1) * (len0 + 1)) start[0] = 1'b0;
      if (n1 > 0 && g == (n1 - 1) * (len1 + 1)) start[1] = 1'b0;
      if (g == abort_at) begin
        Clear = 1'b1;
        @(posedge Clock); #1;
        check("w1_after_clear", obs[0], '0);
        check("w3_after_clear", obs[1], '0);
        Clear = 1'b0;
        return;
      end
      @(posedge Clock); #1;
    end
  endtask

  initial begin
    int op;
    Clear    = 1'b1;
    start[0] = 1'b0;
    start[1] = 1'b0;
    ir       = '0;
    repeat (2) @(posedge Clock);
    #1;
    check("w1_reset", obs[0], '0);
    check("w3_reset", obs[1], '0);
    Clear = 1'b0;

    run(3, 5, 2, 4, 1, 1, -1);     // AND R5,R2,R4
    run(31, 0, 0, 0, 1, 1, -1);    // unsupported opcode
    run(0, 1, 2, 3, 1, 1, 4);      // Clear lands in T4 of the one-wait instance
    run(3, 5, 2, 4, 1, 1, -1);     // normal completion after Clear
    run(0, 7, 8, 9, 2, 1, -1);     // start held across two ADDs
    run(15, 0, 2, 4, 1, 1, -1);    // MUL
    run(16, 9, 1, 14, 1, 1, -1);   // DIV
    run(8, 15, 15, 15, 1, 1, -1);  // highest ALU op, highest register
    run(9, 0, 0, 0, 1, 1, -1);     // first unsupported opcode
    run(17, 3, 3, 3, 1, 1, -1);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0:       op = $urandom_range(9, 31);
        1:       op = ($urandom_range(0, 1) == 0) ? 15 : 16;
        default: op = $urandom_range(0, 8);
      endcase
      run(op, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
          $urandom_range(1, 2), $urandom_range(0, 1), -1);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
